vlane_perm_unit: RTL and testbench
==================================

VLANE_PERM_UNIT -- requirements
Module: vlane_perm_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, number of vector lanes served.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, per-lane datapath width in bits; total bytes NB = LANES*DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports lane_perm_slideup, lane_perm_slidedown, lane_perm_group, lane_perm_gather  input  LANES each  per-lane request pulses, 1 cycle.
REQ-006 SHALL have port lane_perm_input  input  LANES*DATA_WIDTH  source vector; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port lane_perm_vector  input  LANES*DATA_WIDTH  gather byte indices, one 8-bit index per byte.
REQ-008 SHALL have port lane_perm_scalar  input  LANES*DATA_WIDTH  slide byte offset; only the lane-0 slice is used.
REQ-009 SHALL have port lane_perm_mask  input  LANES*DATA_WIDTH/8  per-byte active mask.
REQ-010 SHALL have port lane_perm_result  output  LANES*DATA_WIDTH  permuted result, lane-sliced as the input.
REQ-011 SHALL have ports perm_busy  output  1  iterative operation in progress, and perm_done  output  1  1-cycle pulse when the result updates.
REQ-012 SHALL have port perm_error  output  1  sticky error flag.

Function
REQ-013 SHALL accept a request in cycle T when lane 0 asserts exactly one op flag and perm_busy=0; all operands are registered at the end of cycle T.
REQ-014 SHALL set perm_error when the op flags differ between lanes, or when lane 0 asserts more than one flag; the request is then dropped and the result is left unchanged.
REQ-015 SHALL ignore requests while perm_busy=1; perm_error is not set by an ignored request.
REQ-016 Slideup SHALL give out byte j = in[j-off] if j>=off, else 0; off = lane-0 scalar, unsigned, full width.
REQ-017 Slidedown SHALL give out byte j = in[j+off] if j+off<NB, else 0; an offset >= NB yields all zero for both slide directions.
REQ-018 Gather SHALL give out byte j = in[idx_j] if idx_j<NB, else 0; idx_j = vector byte j.
REQ-019 For slide and gather, a byte with mask=0 SHALL output 0.
REQ-020 Slide and gather SHALL update lane_perm_result at the end of cycle T+1, so the result is valid from cycle T+2; perm_done SHALL be high in cycle T+2.
REQ-021 Group (compress) SHALL pack the bytes with mask=1, in ascending order, into the lowest result bytes and fill the remaining bytes with 0.
REQ-022 Group SHALL be iterative, one lane per cycle, through the FSM IDLE -> COLLECT (LANES cycles, lane counter 0..LANES-1) -> DONE -> IDLE.
REQ-023 During group, perm_busy SHALL be 1 from cycle T+1 through the DONE cycle.
REQ-024 For group, lane_perm_result SHALL update at the DONE exit, valid from cycle T+LANES+2; perm_done SHALL pulse in that same cycle.
REQ-025 Slide and gather SHALL bypass COLLECT and use the FSM path IDLE -> DONE -> IDLE.
REQ-026 lane_perm_result SHALL hold its value until the next perm_done.
REQ-027 The pack write pointer SHALL saturate at NB and never wrap.
REQ-028 A request arriving in the same cycle as a DONE exit SHALL be accepted, because perm_busy is already 0 in that cycle.

Reset
REQ-029 When rst=1 at a rising edge: lane_perm_result=0, perm_busy=0, perm_done=0, perm_error=0, FSM=IDLE, lane counter=0, pack pointer=0.
REQ-030 Reset mid-operation SHALL abort the operation with no perm_done; the result remains 0 after reset.
REQ-031 perm_error SHALL clear only on reset.

Verification
REQ-032 Slideup: input bytes = index (0..31), off=3, mask all 1 -> result bytes 0..2 = 0 and byte j = j-3; perm_done at T+2.
REQ-033 Slidedown: off=40 (>= NB=32) -> result all zero; off=0 -> result equals input.
REQ-034 Gather: idx_j = 31-j except idx_5 = 200 -> result is the byte-reversed input with byte 5 = 0.
REQ-035 Group: mask = 0xAAAAAAAA, input bytes = j -> low 16 bytes = 1,3,...,31 and upper 16 bytes = 0; perm_busy high T+1..T+5; perm_done at T+6.
REQ-036 Lane 0 asserts slideup while lane 2 asserts gather -> perm_error=1, result unchanged, no perm_done.
REQ-037 Reset asserted at T+3 of a group operation -> no perm_done, all outputs 0; a new slideup at T+5 completes normally.

Source files
------------

// File: rtl/vlane_perm_unit.sv
// Vector lane permute unit: slide up/down and byte gather complete in two cycles,
// group (mask compress) walks one lane per cycle before publishing the result.
module vlane_perm_unit #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              lane_perm_slideup,
    input  logic [LANES-1:0]              lane_perm_slidedown,
    input  logic [LANES-1:0]              lane_perm_group,
    input  logic [LANES-1:0]              lane_perm_gather,
    input  logic [LANES*DATA_WIDTH-1:0]   lane_perm_input,
    input  logic [LANES*DATA_WIDTH-1:0]   lane_perm_vector,
    input  logic [LANES*DATA_WIDTH-1:0]   lane_perm_scalar,
    input  logic [LANES*DATA_WIDTH/8-1:0] lane_perm_mask,
    output logic [LANES*DATA_WIDTH-1:0]   lane_perm_result,
    output logic                          perm_busy,
    output logic                          perm_done,
    output logic                          perm_error
);
    localparam int W   = LANES * DATA_WIDTH;
    localparam int NB  = W / 8;
    localparam int BPL = DATA_WIDTH / 8;
    localparam int AW  = $clog2(NB);
    localparam int PW  = $clog2(NB + 1);
    localparam int IW  = PW + 1;
    localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_SLIDEUP, OP_SLIDEDOWN, OP_GROUP, OP_GATHER} op_t;

    state_t              state_reg;
    op_t                 op_reg, op_next;
    logic [CW-1:0]       cnt_reg;
    logic [PW-1:0]       ptr_reg, ptr_next;
    logic                busy_reg, done_reg, error_reg;
    logic [W-1:0]        result_reg, data_reg, vec_reg;
    logic [DATA_WIDTH-1:0] off_reg;
    logic [NB-1:0]       mask_reg;
    logic [7:0]          pack_reg [NB];
    logic [7:0]          pack_next [NB];
    logic [7:0]          perm_bytes [NB];
    logic [7:0]          in_bytes [NB];
    logic [7:0]          vec_bytes [NB];
    logic [7:0]          lane_data [LANES][BPL];
    logic [BPL-1:0]      lane_mask [LANES];
    logic [W-1:0]        perm_flat, pack_flat;
    logic [3:0]          lane_flags [LANES];
    logic [LANES-1:0]    mismatch_vec;
    logic [3:0]          flags0;
    logic                multi, req_ok, req_bad;

    // Per-lane flag nibbles; any disagreement with lane 0 is a malformed request.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_flags[gi]   = {lane_perm_gather[gi], lane_perm_group[gi],
                                       lane_perm_slidedown[gi], lane_perm_slideup[gi]};
            assign mismatch_vec[gi] = (lane_flags[gi] != lane_flags[0]);
            assign lane_mask[gi]    = mask_reg[gi*BPL +: BPL];
            for (genvar gj = 0; gj < BPL; gj++) begin : g_byte
                assign lane_data[gi][gj] = data_reg[(gi*BPL+gj)*8 +: 8];
            end
        end
        for (genvar gi = 0; gi < NB; gi++) begin : g_flat
            assign in_bytes[gi]        = data_reg[gi*8 +: 8];
            assign vec_bytes[gi]       = vec_reg[gi*8 +: 8];
            assign perm_flat[gi*8 +: 8] = perm_bytes[gi];
            assign pack_flat[gi*8 +: 8] = pack_reg[gi];
        end
        if (LANES > 1) begin : g_unused
            logic unused_scalar;
            assign unused_scalar = ^lane_perm_scalar[W-1:DATA_WIDTH];
        end
    endgenerate

    assign flags0  = lane_flags[0];
    assign multi   = |(flags0 & (flags0 - 4'd1));
    assign req_bad = !busy_reg && ((|mismatch_vec) || multi);
    assign req_ok  = !busy_reg && !(|mismatch_vec) && !multi && (flags0 != 4'd0);

    always_comb begin
        op_next = OP_SLIDEUP;
        if (flags0[1])      op_next = OP_SLIDEDOWN;
        else if (flags0[2]) op_next = OP_GROUP;
        else if (flags0[3]) op_next = OP_GATHER;
    end

    // Slide and gather are evaluated from the registered operands during DONE.
    always_comb begin
        logic [IW-1:0] src;
        logic          off_ok;
        logic [IW-1:0] off_s;
        off_ok = (off_reg < DATA_WIDTH'(NB));
        off_s  = off_reg[IW-1:0];
        src    = '0;
        for (int j = 0; j < NB; j++) begin
            perm_bytes[j] = 8'd0;
            case (op_reg)
                OP_SLIDEUP: begin
                    src = IW'(j) - off_s;
                    if (off_ok && IW'(j) >= off_s) perm_bytes[j] = in_bytes[src[AW-1:0]];
                end
                OP_SLIDEDOWN: begin
                    src = IW'(j) + off_s;
                    if (off_ok && src < IW'(NB)) perm_bytes[j] = in_bytes[src[AW-1:0]];
                end
                OP_GATHER: begin
                    if (int'(vec_bytes[j]) < NB) perm_bytes[j] = in_bytes[vec_bytes[j][AW-1:0]];
                end
                default: ;
            endcase
            if (!mask_reg[j]) perm_bytes[j] = 8'd0;
        end
    end

    // Compress the current lane's active bytes onto the pack buffer; pointer saturates at NB.
    always_comb begin
        pack_next = pack_reg;
        ptr_next  = ptr_reg;
        for (int b = 0; b < BPL; b++) begin
            if (lane_mask[cnt_reg][b] && ptr_next < PW'(NB)) begin
                pack_next[ptr_next[AW-1:0]] = lane_data[cnt_reg][b];
                ptr_next = ptr_next + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= OP_SLIDEUP;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
            result_reg <= '0;
            data_reg   <= '0;
            vec_reg    <= '0;
            off_reg    <= '0;
            mask_reg   <= '0;
            for (int k = 0; k < NB; k++) pack_reg[k] <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            if (req_bad) error_reg <= 1'b1;
            case (state_reg)
                S_IDLE: begin
                    if (req_ok) begin
                        op_reg   <= op_next;
                        data_reg <= lane_perm_input;
                        vec_reg  <= lane_perm_vector;
                        off_reg  <= lane_perm_scalar[DATA_WIDTH-1:0];
                        mask_reg <= lane_perm_mask;
                        cnt_reg  <= '0;
                        ptr_reg  <= '0;
                        busy_reg <= 1'b1;
                        for (int k = 0; k < NB; k++) pack_reg[k] <= 8'd0;
                        state_reg <= (op_next == OP_GROUP) ? S_COLLECT : S_DONE;
                    end
                end
                S_COLLECT: begin
                    pack_reg <= pack_next;
                    ptr_reg  <= ptr_next;
                    if (cnt_reg == CW'(LANES - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_DONE: begin
                    result_reg <= (op_reg == OP_GROUP) ? pack_flat : perm_flat;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign lane_perm_result = result_reg;
    assign perm_busy        = busy_reg;
    assign perm_done        = done_reg;
    assign perm_error       = error_reg;
endmodule

// File: tb/tb_vlane_perm_unit.sv
// Directed bench for vlane_perm_unit: slides, gather, group timing, error and reset behaviour.
module tb_vlane_perm_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   slideup, slidedown, group, gather;
    logic [255:0] din, vec, scalar, result;
    logic [31:0]  mask;
    logic         busy, done, error;
    int           checks = 0;
    int           failures = 0;
    logic [255:0] ramp, exp_su3, exp_v;

    always #5 clk = ~clk;

    vlane_perm_unit #(.LANES(4), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .lane_perm_slideup(slideup), .lane_perm_slidedown(slidedown),
        .lane_perm_group(group), .lane_perm_gather(gather),
        .lane_perm_input(din), .lane_perm_vector(vec), .lane_perm_scalar(scalar),
        .lane_perm_mask(mask), .lane_perm_result(result),
        .perm_busy(busy), .perm_done(done), .perm_error(error)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] su, input logic [3:0] sd,
                             input logic [3:0] gr, input logic [3:0] ga);
        slideup = su; slidedown = sd; group = gr; gather = ga;
    endtask

    // Drive a request for one cycle; returns in cycle T+1 with flags cleared.
    task automatic pulse(input logic [3:0] su, input logic [3:0] sd,
                         input logic [3:0] gr, input logic [3:0] ga);
        set_flags(su, sd, gr, ga);
        step();
        set_flags(4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic run_simple(input string tag, input logic [3:0] su, input logic [3:0] sd,
                              input logic [3:0] ga, input logic [255:0] exp);
        pulse(su, sd, 4'h0, ga);
        chk({tag, "_done_t1"}, done, 1'b0);
        step();
        chk({tag, "_done_t2"}, done, 1'b1);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_done_t3"}, done, 1'b0);
        $display("txn %s result=%h", tag, result);
    endtask

    initial begin
        rst = 1'b1;
        set_flags(4'h0, 4'h0, 4'h0, 4'h0);
        din = '0; vec = '0; scalar = '0; mask = '0;
        for (int j = 0; j < 32; j++) ramp[j*8 +: 8] = 8'(j);
        for (int j = 0; j < 32; j++) exp_su3[j*8 +: 8] = (j >= 3) ? 8'(j - 3) : 8'd0;
        step(); step();
        chk("rst_result", result, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        rst = 1'b0;
        $display("txn reset");

        din = ramp; mask = 32'hFFFF_FFFF; scalar = 256'd3;
        run_simple("slideup3", 4'hF, 4'h0, 4'h0, exp_su3);
        chk("hold_result", result, exp_su3);

        scalar = 256'd40;
        run_simple("slidedown40", 4'h0, 4'hF, 4'h0, '0);
        scalar = 256'd0;
        run_simple("slidedown0", 4'h0, 4'hF, 4'h0, ramp);

        scalar = 256'd1; mask = 32'h0000_FFFF;
        for (int j = 0; j < 32; j++) exp_v[j*8 +: 8] = (j < 16) ? 8'(j + 1) : 8'd0;
        run_simple("slidedown1_mask", 4'h0, 4'hF, 4'h0, exp_v);

        mask = 32'hFFFF_FFFF;
        for (int j = 0; j < 32; j++) vec[j*8 +: 8] = 8'(31 - j);
        vec[5*8 +: 8] = 8'd200;
        for (int j = 0; j < 32; j++) exp_v[j*8 +: 8] = (j == 5) ? 8'd0 : 8'(31 - j);
        run_simple("gather", 4'h0, 4'h0, 4'hF, exp_v);

        // Group with ignored requests while busy and a back-to-back request on the done cycle.
        mask = 32'hAAAA_AAAA;
        exp_v = '0;
        for (int k = 0; k < 16; k++) exp_v[k*8 +: 8] = 8'(2*k + 1);
        pulse(4'h0, 4'h0, 4'hF, 4'h0);
        for (int t = 1; t <= 5; t++) begin
            chk($sformatf("grp_busy_t%0d", t), busy, 1'b1);
            chk($sformatf("grp_done_t%0d", t), done, 1'b0);
            if (t == 2) set_flags(4'b0001, 4'h0, 4'h0, 4'b0010);
            else if (t == 3) set_flags(4'h0, 4'hF, 4'h0, 4'h0);
            else set_flags(4'h0, 4'h0, 4'h0, 4'h0);
            step();
        end
        chk("grp_busy_t6", busy, 1'b0);
        chk("grp_done_t6", done, 1'b1);
        chk("grp_result", result, exp_v);
        chk("grp_ignored_no_error", error, 1'b0);
        $display("txn group result=%h", result);
        mask = 32'hFFFF_FFFF; scalar = 256'd3;
        pulse(4'hF, 4'h0, 4'h0, 4'h0);
        chk("b2b_done_t7", done, 1'b0);
        step();
        chk("b2b_done_t8", done, 1'b1);
        chk("b2b_result", result, exp_su3);
        $display("txn back_to_back_slideup result=%h", result);

        // Lanes disagree: error, request dropped.
        step();
        pulse(4'b0001, 4'h0, 4'h0, 4'b0100);
        chk("mis_error", error, 1'b1);
        chk("mis_done_t1", done, 1'b0);
        chk("mis_busy_t1", busy, 1'b0);
        step();
        chk("mis_done_t2", done, 1'b0);
        chk("mis_result", result, exp_su3);
        $display("txn lane_mismatch error=%0d", error);

        // Reset at T+3 of a group aborts it; a slideup at T+5 then runs normally.
        mask = 32'hAAAA_AAAA;
        pulse(4'h0, 4'h0, 4'hF, 4'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_result", result, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_error", error, 1'b0);
        step();
        mask = 32'hFFFF_FFFF; scalar = 256'd3;
        pulse(4'hF, 4'h0, 4'h0, 4'h0);
        chk("post_rst_done_t6", done, 1'b0);
        chk("post_rst_result_t6", result, '0);
        step();
        chk("post_rst_done_t7", done, 1'b1);
        chk("post_rst_result", result, exp_su3);
        $display("txn reset_abort_then_slideup result=%h", result);

        // Lane 0 with two flags, consistent across lanes: still an error.
        step();
        pulse(4'hF, 4'hF, 4'h0, 4'h0);
        chk("multi_error", error, 1'b1);
        chk("multi_done_t1", done, 1'b0);
        step();
        chk("multi_done_t2", done, 1'b0);
        chk("multi_result", result, exp_su3);
        $display("txn multi_flag error=%0d", error);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
